// File: rtl/crt_pkg.sv
// crt_pkg: shared width default, FSM state encoding and latency for CRT recombination
package crt_pkg;
  localparam int CRT_W = 32;
  localparam int CRT_LAT = 2 * CRT_W + 1;
  typedef enum logic [2:0] {IDLE, DIFF, MODMUL, RECOMB, DONE} crt_state_t;
endpackage

// File: rtl/crt_modmul_step.sv
// crt_modmul_step: one interleaved modular multiply step, nxt = (2*acc + b*d) mod p
//   acc, d, p : W-bit operands, acc < p and d < p
//   b         : current multiplier bit
//   nxt       : W-bit reduced result
module crt_modmul_step
  import crt_pkg::*;
#(
  parameter int W = CRT_W
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] d,
  input  logic [W-1:0] p,
  input  logic         b,
  output logic [W-1:0] nxt
);
  logic [W+1:0] pp, t0, t1, t2;
  always_comb begin
    pp = {2'b0, p};
    t0 = {1'b0, acc, 1'b0};
    t1 = t0 >= pp ? t0 - pp : t0;
    t2 = b ? t1 + {2'b0, d} : t1;
    nxt = W'(t2 >= pp ? t2 - pp : t2);
  end
endmodule

// File: rtl/crt_recombine.sv
// crt_recombine: Garner CRT recombination, m = m2 + q * (qinv * (m1 - m2) mod p)
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : request, operands captured when idle
//   p, q, qinv, m1, m2   : W-bit CRT operands
//   m                    : 2W-bit result, updated only with done
//   busy, done           : run in progress, one-cycle completion pulse
module crt_recombine
  import crt_pkg::*;
#(
  parameter int W = CRT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   p,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   qinv,
  input  logic [W-1:0]   m1,
  input  logic [W-1:0]   m2,
  output logic [2*W-1:0] m,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  crt_state_t st;
  logic [W-1:0] rp, rqi, rm1, rm2, d, acc, acc_nxt;
  logic [2*W-1:0] rq, prod, pp;
  logic [CW-1:0] cnt;
  crt_modmul_step #(.W(W)) u_step (.acc(acc), .d(d), .p(rp), .b(rqi[W-1]), .nxt(acc_nxt));
  // in RECOMB acc holds h and is consumed LSB-first against a left-shifting q
  always_comb pp = acc[0] ? rq : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      rp <= '0;
      rq <= '0;
      rqi <= '0;
      rm1 <= '0;
      rm2 <= '0;
      d <= '0;
      acc <= '0;
      prod <= '0;
      cnt <= '0;
      m <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          rp <= p;
          rq <= {{W{1'b0}}, q};
          rqi <= qinv;
          rm1 <= m1;
          rm2 <= m2;
          acc <= '0;
          cnt <= '0;
          busy <= 1'b1;
          st <= DIFF;
        end
        DIFF: begin
          // W+1-bit intermediate so m1 + p cannot overflow on the borrow path
          d <= W'(rm1 >= rm2 ? {1'b0, rm1} - {1'b0, rm2} : {1'b0, rm1} + {1'b0, rp} - {1'b0, rm2});
          prod <= {{W{1'b0}}, rm2};
          st <= MODMUL;
        end
        MODMUL: begin
          acc <= acc_nxt;
          rqi <= rqi << 1;
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) st <= RECOMB;
        end
        RECOMB: begin
          prod <= prod + pp;
          rq <= rq << 1;
          acc <= acc >> 1;
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            m <= prod + pp;
            done <= 1'b1;
            busy <= 1'b0;
            st <= DONE;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crt_recombine.sv
// tb_crt_recombine: randomized and directed check of crt_recombine against an arithmetic model
module tb_crt_recombine;
  localparam int W = 32;
  localparam int LAT = 2 * W + 1;
  localparam logic [63:0] BP = 64'd4294967291;
  localparam logic [63:0] BQ = 64'd4294967279;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] p = 0, q = 0, qinv = 0, m1 = 0, m2 = 0;
  logic [2*W-1:0] m;
  logic busy, done;
  int tests = 0, fails = 0;
  int cyc = 0, se = 0, k;
  bit act = 0, armed = 0, e_busy = 0, e_done = 0, got;
  logic [63:0] e_m = 0, pend = 0, res, bqi, mm;

  crt_recombine #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .p(p), .q(q), .qinv(qinv),
                              .m1(m1), .m2(m2), .m(m), .busy(busy), .done(done));
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] a_p, a_q, a_qi, a_m1, a_m2);
    logic [63:0] h;
    h = (a_qi * ((a_m1 + a_p - a_m2) % a_p)) % a_p;
    return a_m2 + h * a_q;
  endfunction

  function automatic logic [63:0] modinv(input logic [63:0] a, input logic [63:0] md);
    logic [63:0] r, b, e;
    r = 1;
    b = a % md;
    e = md - 2;
    while (e != 0) begin
      if (e[0]) r = (r * b) % md;
      b = (b * b) % md;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    end
  endtask

  // expected outputs after each edge, from the acceptance and latency rules
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      act = 0;
      e_m = 0;
      armed = 1;
    end else if (act) begin
      k = cyc - se;
      if (k == LAT) e_m = pend;
      if (k == LAT + 1) act = 0;
    end else if (start) begin
      act = 1;
      se = cyc;
      pend = model({32'd0, p}, {32'd0, q}, {32'd0, qinv}, {32'd0, m1}, {32'd0, m2});
    end
    k = cyc - se;
    e_busy = act && k < LAT;
    e_done = act && k == LAT;
  end

  always @(negedge clk) if (armed) begin
    tests++;
    if ({busy, done, m} !== {e_busy, e_done, e_m}) begin
      fails++;
      $display("FAIL cycle %0d: busy/done/m got %b/%b/%0d, expected %b/%b/%0d",
               cyc, busy, done, m, e_busy, e_done, e_m);
    end
  end

  task automatic go(input logic [63:0] a_p, a_q, a_qi, a_m1, a_m2, input int spike, input int rst_at,
                    output logic [63:0] r, output bit g);
    @(negedge clk);
    p = a_p[W-1:0];
    q = a_q[W-1:0];
    qinv = a_qi[W-1:0];
    m1 = a_m1[W-1:0];
    m2 = a_m2[W-1:0];
    start = 1;
    g = 0;
    r = 0;
    for (int i = 1; i <= 200 && !g; i++) begin
      @(negedge clk);
      if (done) begin
        g = 1;
        r = m;
      end
      start = (i == spike) || (i == rst_at);
      rst_n = (i != rst_at);
      p = $urandom;
      q = $urandom;
      qinv = $urandom;
      m1 = $urandom;
      m2 = $urandom;
    end
    start = 0;
    rst_n = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 0);
    check("reset_done", {63'd0, done}, 0);
    check("reset_m", m, 0);
    rst_n = 1;
    check("model_inv", modinv(7, 11), 8);
    check("model_a", model(11, 7, 8, 6, 1), 50);
    check("model_b", model(11, 7, 8, 2, 6), 13);
    check("model_c", model(11, 7, 8, 9, 6), 20);
    check("model_d", model(11, 7, 8, 3, 3), 3);
    go(11, 7, 8, 6, 1, 0, 0, res, got);
    check("basic_done", {63'd0, got}, 1);
    check("basic_m", res, 50);
    go(11, 7, 8, 2, 6, 0, 0, res, got);
    check("borrow_m", res, 13);
    go(11, 7, 8, 9, 6, 0, 0, res, got);
    check("nob_m", res, 20);
    go(11, 7, 8, 3, 3, 10, 0, res, got);
    check("eq_spike_done", {63'd0, got}, 1);
    check("eq_spike_m", res, 3);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("done_start_busy", {63'd0, busy}, 0);
    check("done_start_m", m, 3);
    go(11, 7, 0, 6, 1, 0, 0, res, got);
    check("qinv0_m", res, 1);
    go(11, 7, 8, 5, 1, 0, 30, res, got);
    check("rst_no_done", {63'd0, got}, 0);
    check("rst_m", m, 0);
    go(11, 7, 8, 6, 1, 0, 0, res, got);
    check("restart_done", {63'd0, got}, 1);
    check("restart_m", res, 50);
    bqi = modinv(BQ, BP);
    check("big_inv", (bqi * BQ) % BP, 1);
    for (int n = 0; n < 1000; n++) begin
      mm = {$urandom, $urandom} % (BP * BQ);
      go(BP, BQ, bqi, mm % BP, mm % BQ, 0, 0, res, got);
      check("rand_done", {63'd0, got}, 1);
      check("rand_m", res, mm);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crt_recombine.md
CRT_RECOMBINE -- requirements
Module: crt_recombine

Interface
REQ-001 SHALL have one clock and one synchronous, active-low reset; clock: clk, reset: rst_n.
REQ-002 SHALL expose parameter W, default 32, operand width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  one-cycle request; operands are sampled when start=1 in IDLE.
REQ-006 p  input  W  larger CRT prime, odd, p > q.
REQ-007 q  input  W  smaller CRT prime, odd.
REQ-008 qinv  input  W  q^-1 mod p, produced by the n0prime/qinv stage; qinv < p.
REQ-009 m1  input  W  c^dp mod p; m1 < p.
REQ-010 m2  input  W  c^dq mod q; m2 < q.
REQ-011 m  output  2W  recombined plaintext m2 + q*h.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse; m is valid.

Function
REQ-014 SHALL compute h = qinv*(m1-m2) mod p and m = m2 + h*q (Garner recombination).
REQ-015 SHALL have FSM states IDLE, DIFF, MODMUL, RECOMB, DONE.
- IDLE->DIFF on start; DIFF->MODMUL; MODMUL->RECOMB after W iterations; RECOMB->DONE after W iterations; DONE->IDLE.
REQ-016 SHALL, in IDLE with start=1, register p, q, qinv, m1, m2; later input changes SHALL NOT affect the result.
REQ-017 In DIFF, SHALL compute d = m1-m2 if m1>=m2, else m1+p-m2, using a W+1-bit intermediate; result 0 <= d < p.
REQ-018 In MODMUL, SHALL process qinv MSB-first, one bit per cycle:
- acc = 2*acc mod p;
- then, if the bit is 1, acc = (acc+d) mod p;
- at most two conditional subtractions of p per step; intermediate width W+2 bits; acc starts at 0.
REQ-019 In RECOMB, SHALL compute h*q by LSB-first shift-add, one bit of h per cycle, into a 2W-bit accumulator preloaded with m2.
REQ-020 Latency SHALL be fixed: done=1 in the cycle following clock edge 2W+1 after the edge that sampled start (65 edges for W=32).
REQ-021 done SHALL be high for exactly one cycle; busy SHALL be 0 in that cycle.
REQ-022 m SHALL update only when done asserts, and SHALL hold until the next done.
REQ-023 start while busy=1 or in DONE SHALL be ignored, with no effect on the running operation.
REQ-024 m1==m2 or qinv==0 SHALL give h=0 and m=m2, with unchanged latency.
REQ-025 Behaviour for inputs violating REQ-006..REQ-010 is unspecified, but the FSM SHALL still reach IDLE within the REQ-020 latency.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, m=0, and clear all counters and accumulators.
REQ-027 Reset mid-operation SHALL abort with no done pulse; the next start after reset SHALL run a full normal operation.
REQ-028 start sampled on the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-029 Package crt_pkg SHALL hold the W default, the FSM state enum, and the latency constant CRT_LAT = 2W+1.
REQ-030 One sub-module, crt_modmul_step, SHALL implement a single combinational interleaved-modular step (double, conditional add, reduce); the top block holds the FSM, counters and registers.
REQ-031 SHALL NOT use a full W x W multiplier; arithmetic is limited to adders, subtractors and comparators.

Verification
REQ-032 p=11, q=7, qinv=8, m1=6, m2=1, start -> done after 65 edges, m=50.
REQ-033 p=11, q=7, qinv=8, m1=2, m2=6 (borrow path) -> m=13; m1=9, m2=6 -> m=20.
REQ-034 m1=m2=3, p=11, q=7, qinv=8 -> m=3; a second start pulsed at cycle 10 of the run is ignored.
REQ-035 Reset asserted at cycle 30 of a run -> no done, m=0; a restart with p=11, q=7, qinv=8, m1=6, m2=1 -> m=50.
REQ-036 p=4294967291, q=4294967279, 1000 random M < p*q -> m == M versus the behavioural model; qinv from the model.
